// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and requester ids for the two-port data-memory arbiter.
package data_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arbState_t;

    localparam logic REQ_CPU  = 1'b0;
    localparam logic REQ_UART = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_rr_pick2.sv
// Two-way round-robin winner selection; pointer names the favoured port on a tie.
module rr_pick2
    import data_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       pointer,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = REQ_CPU;
        if (req[0] && req[1])
            grant = pointer;
        else if (req[1])
            grant = REQ_UART;
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates a CPU port and a UART/debug port onto one registered-read data memory.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_id
);

    arbState_t               state, stateNext;
    logic                    pointer;
    logic                    pickGrant, pickValid;
    logic                    winId, winWe;
    logic [ADDR_W-1:0]       latAddr;
    logic [DATA_W-1:0]       latWdata;
    logic [1:0]              ackQ;
    logic [1:0][DATA_W-1:0]  rdataQ;

    rr_pick2 uPick (
        .req     ({m1_req, m0_req}),
        .pointer (pointer),
        .grant   (pickGrant),
        .valid   (pickValid)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (pickValid) stateNext = ACCESS;
            ACCESS:  stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Ack and rdata are registered together at the end of RESP, so the load
    // data is already valid in the ack cycle and stays held afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pointer  <= REQ_CPU;
            winId    <= REQ_CPU;
            winWe    <= 1'b0;
            latAddr  <= '0;
            latWdata <= '0;
            ackQ     <= '0;
            rdataQ   <= '0;
        end else begin
            ackQ <= '0;
            if (state == IDLE && pickValid) begin
                winId    <= pickGrant;
                winWe    <= pickGrant ? m1_we    : m0_we;
                latAddr  <= pickGrant ? m1_addr  : m0_addr;
                latWdata <= pickGrant ? m1_wdata : m0_wdata;
                pointer  <= ~pickGrant;
            end
            if (state == RESP) begin
                ackQ[winId] <= 1'b1;
                if (!winWe) rdataQ[winId] <= mem_rdata;
            end
        end
    end

    // Strobe is decoded from state so an async reset kills it immediately.
    assign mem_write   = (state == ACCESS) && winWe;
    assign mem_address = latAddr;
    assign mem_wdata   = latWdata;
    assign busy        = (state != IDLE);
    assign grant_id    = (state == IDLE) ? REQ_CPU : winId;
    assign m0_ack      = ackQ[0];
    assign m1_ack      = ackQ[1];
    assign m0_rdata    = rdataQ[0];
    assign m1_rdata    = rdataQ[1];

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a registered-read word memory model.
module tb_data_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clock, reset;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [ADDR_W-1:0] m0_addr, m1_addr, mem_address;
    logic [DATA_W-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic              m0_ack, m1_ack, mem_write, busy, grant_id;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    logic [DATA_W-1:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word memory, data returned one cycle after the address
    always @(posedge clock) begin
        if (mem_write) mem[mem_address[9:2]] <= mem_wdata;
        mem_rdata <= mem[mem_address[9:2]];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_memwrite", mem_write, 0);
        chk("rst_acks", {m0_ack, m1_ack}, 0);
        chk("rst_rdata0", m0_rdata, 0);
        chk("rst_rdata1", m1_rdata, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_wdata", mem_wdata, 0);
        reset = 1'b0;
    endtask

    task automatic test_load();
        mem[8'h04] = 32'hCAFEF00D;
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        tick();
        chk("ld_access_busy", busy, 1);
        chk("ld_access_grant", grant_id, 0);
        chk("ld_access_addr", mem_address, 32'h10);
        chk("ld_access_memwrite", mem_write, 0);
        chk("ld_access_ack", m0_ack, 0);
        tick();
        chk("ld_resp_memwrite", mem_write, 0);
        chk("ld_resp_ack", m0_ack, 0);
        tick();
        chk("ld_ack", m0_ack, 1);
        chk("ld_rdata", m0_rdata, 32'hCAFEF00D);
        chk("ld_idle_busy", busy, 0);
        chk("ld_idle_memwrite", mem_write, 0);
        m0_req = 0;
        tick();
        chk("ld_ack_pulse", m0_ack, 0);
        chk("ld_rdata_held", m0_rdata, 32'hCAFEF00D);
        chk("ld_no_repeat", busy, 0);
    endtask

    task automatic test_store();
        m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
        tick();
        chk("st_memwrite", mem_write, 1);
        chk("st_addr", mem_address, 32'h20);
        chk("st_wdata", mem_wdata, 32'h12345678);
        chk("st_grant", grant_id, 1);
        tick();
        chk("st_resp_memwrite", mem_write, 0);
        chk("st_resp_addr_held", mem_address, 32'h20);
        tick();
        chk("st_ack", {m1_ack, m0_ack}, 2'b10);
        chk("st_rdata_untouched", m1_rdata, 0);
        chk("st_mem", mem[8'h08], 32'h12345678);
        m1_req = 0; m1_we = 0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h20;
        tick(); tick(); tick();
        chk("st_readback_ack", m0_ack, 1);
        chk("st_readback", m0_rdata, 32'h12345678);
        m0_req = 0;
        tick();
    endtask

    task automatic test_round_robin();
        mem[8'h0C] = 32'hA0A0A0A0;
        mem[8'h0D] = 32'hB1B1B1B1;
        reset = 1;
        m0_req = 1; m0_we = 0; m0_addr = 32'h30;
        m1_req = 1; m1_we = 0; m1_addr = 32'h34;
        tick();
        reset = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("rr_m0_ack", m0_ack, (k % 6 == 3));
            chk("rr_m1_ack", m1_ack, (k % 6 == 0));
            if (k % 3 == 1) chk("rr_grant", grant_id, ((k - 1) / 3) % 2);
            if (k % 6 == 3) chk("rr_rdata0", m0_rdata, 32'hA0A0A0A0);
            if (k % 6 == 0) chk("rr_rdata1", m1_rdata, 32'hB1B1B1B1);
        end
        m0_req = 0; m1_req = 0;
        tick();
    endtask

    task automatic test_reset_abort();
        mem[8'h10] = 32'hAAAA5555;
        m0_req = 1; m0_we = 1; m0_addr = 32'h40; m0_wdata = 32'hDEADBEEF;
        tick();
        chk("ab_memwrite_before", mem_write, 1);
        #2 reset = 1;
        #1;
        chk("ab_memwrite_dropped", mem_write, 0);
        chk("ab_busy_dropped", busy, 0);
        m0_req = 0; m0_we = 0;
        tick();
        chk("ab_no_ack1", {m0_ack, m1_ack}, 0);
        tick();
        chk("ab_no_ack2", {m0_ack, m1_ack}, 0);
        reset = 0;
        chk("ab_mem_unchanged", mem[8'h10], 32'hAAAA5555);
        m0_req = 1; m0_addr = 32'h40;
        tick(); tick(); tick();
        chk("ab_readback_ack", m0_ack, 1);
        chk("ab_readback", m0_rdata, 32'hAAAA5555);
        m0_req = 0;
        tick();
    endtask

    task automatic test_input_change();
        mem[8'h14] = 32'h11112222;
        mem[8'h15] = 32'h33334444;
        m0_req = 1; m0_we = 0; m0_addr = 32'h50;
        tick();
        m0_addr = 32'h54; m0_wdata = 32'h99999999; m0_we = 1; m0_req = 0;
        #1;
        chk("ic_addr_latched", mem_address, 32'h50);
        chk("ic_no_write", mem_write, 0);
        tick();
        chk("ic_resp_no_write", mem_write, 0);
        tick();
        chk("ic_ack", m0_ack, 1);
        chk("ic_rdata", m0_rdata, 32'h11112222);
        chk("ic_mem_untouched", mem[8'h15], 32'h33334444);
        m0_we = 0;
        tick();
        chk("ic_idle", busy, 0);
    endtask

    task automatic test_back_to_back();
        m1_req = 1; m1_we = 0; m1_addr = 32'h10;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("b2b_ack", m1_ack, (k % 3 == 0));
            if (k == 4) chk("b2b_grant", grant_id, 1);
        end
        chk("b2b_rdata", m1_rdata, 32'hCAFEF00D);
        m1_req = 0;
        tick();
    endtask

    initial begin
        reset = 1; m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_load();
        test_store();
        test_round_robin();
        test_reset_abort();
        test_input_change();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of both requesters and the memory port.
REQ-002 Parameter DATA_W, default 32: data width of both requesters and the memory port.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 m0_req  input  1  requester 0 (CPU load/store) access request; held high until m0_ack.
REQ-006 m0_we  input  1  requester 0 write enable: 1 = store, 0 = load.
REQ-007 m0_addr  input  ADDR_W  requester 0 byte address.
REQ-008 m0_wdata  input  DATA_W  requester 0 store data.
REQ-009 m0_ack  output  1  one-cycle pulse; requester 0 transaction complete.
REQ-010 m0_rdata  output  DATA_W  requester 0 load data; valid in the m0_ack cycle, then held.
REQ-011 m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same directions, widths and meanings for requester 1 (UART loader/debug port).
REQ-012 mem_write  output  1  write strobe to the data memory.
REQ-013 mem_address  output  ADDR_W  byte address to the data memory.
REQ-014 mem_wdata  output  DATA_W  write data to the data memory.
REQ-015 mem_rdata  input  DATA_W  read data from the data memory; registered, valid one cycle after the address.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 grant_id  output  1  requester owning the current transaction; 0 in IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-019 IDLE: if any mX_req is high, latch the winner's id, we, addr and wdata; go to ACCESS; otherwise stay in IDLE.
REQ-020 ACCESS (one cycle): drive mem_address/mem_wdata from the latched values, assert mem_write = latched we; go to RESP.
REQ-021 RESP (one cycle): capture mem_rdata into the winner's rdata register, pulse the winner's ack for this cycle only; go to IDLE.
REQ-022 Latency: ack SHALL be high exactly 3 cycles after the cycle in which req is first sampled in IDLE; back-to-back throughput is one transaction per 3 cycles.
REQ-023 Arbitration SHALL be round-robin: a priority pointer selects the winner when both requests are high in IDLE; after each grant the pointer moves to the other requester.
REQ-024 A single requesting port SHALL win regardless of the pointer; the pointer still updates to the non-granted port.
REQ-025 mem_write SHALL be high only in ACCESS with latched we = 1; it SHALL never be high in IDLE or RESP.
REQ-026 In IDLE and RESP, mem_address and mem_wdata SHALL hold the last latched values; no glitching to requester inputs.
REQ-027 A store SHALL NOT update mX_rdata; the ack still pulses.
REQ-028 Inputs changing after the IDLE sample SHALL NOT affect the in-flight transaction.
REQ-029 If req drops before ack, the transaction SHALL still complete and ack SHALL still pulse.
REQ-030 A req held high through its own ack cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-031 Addresses SHALL pass through unmodified, with no alignment check.

Reset
REQ-032 Reset SHALL force the following immediately, independent of clock: state IDLE, pointer to requester 0, mem_write 0, m0_ack/m1_ack 0, busy 0, grant_id 0, all latched/rdata registers 0.
REQ-033 Reset asserted mid-transaction SHALL abort it: no ack is issued and no further memory write occurs.
REQ-034 After reset deasserts, the first pending request SHALL be sampled on the first rising edge.

Structure
REQ-035 A shared package SHALL hold the state enum (IDLE, ACCESS, RESP) and requester-id constants (REQ_CPU = 0, REQ_UART = 1).
REQ-036 Winner selection SHALL be a sub-module rr_pick2 (inputs req[1:0] and pointer; outputs grant and valid); the FSM and datapath registers SHALL be in data_mem_arbiter.

Verification
REQ-037 Reset, then m0 load addr 0x10 with memory[0x10] = 0xCAFEF00D -> m0_ack 3 cycles later, m0_rdata = 0xCAFEF00D, mem_write never high.
REQ-038 m1 store addr 0x20 data 0x12345678 -> mem_write high exactly one cycle (ACCESS) with mem_address 0x20; a later m0 load of 0x20 returns 0x12345678.
REQ-039 Both requests high continuously from reset -> grants alternate m0, m1, m0, m1; acks 3 cycles apart; neither port starves.
REQ-040 Reset pulsed during ACCESS of a store -> mem_write drops immediately; no ack; memory contents unchanged on a later read-back.
REQ-041 m0 changes addr/wdata and drops req one cycle after sampling -> original address used, ack still pulses, m0_rdata from the original address.
